// File: rtl/ssc_txn_ctrl.sv
// ssc_txn_ctrl: request FIFO and single-outstanding launcher in front of the SSC serial core.
// Define SSC_TIMEOUT_EN to build a watchdog that aborts a transaction the core never finishes.
module ssc_txn_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_dir,
  input  logic [4:0]                  req_cmd,
  input  logic [5:0]                  req_len,
  input  logic [4:0]                  req_div,
  input  logic [47:0]                 req_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [4:0]                  rsp_cmd,
  output logic [1:0]                  rsp_status,
  output logic [47:0]                 rsp_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        sscGo,
  output logic                        sscDir,
  output logic [4:0]                  sscCommand,
  output logic [5:0]                  sscDataLength,
  output logic [4:0]                  sscClkDivider,
  output logic [47:0]                 sscDataIn,
  input  logic                        sscBusy,
  input  logic [47:0]                 sscDataOut
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR_LEN = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;
  localparam logic [5:0] MAX_LEN    = 6'd48;

  typedef struct packed {
    logic        dir;
    logic [4:0]  cmd;
    logic [5:0]  len;
    logic [4:0]  div;
    logic [47:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESPOND} state_e;

  req_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;
  req_t          head, req_in, hold_q;
  state_e        state_q;
  logic          go_q;
  logic          rsp_valid_q;
  logic [1:0]    status_q;
  logic [4:0]    rsp_cmd_q;
  logic [47:0]   rsp_data_q;
  logic          wdog_hit;

  // Keeps only the low len bits of the core shift register (len is 0..48 here).
  function automatic logic [47:0] len_mask(input logic [5:0] len);
    logic [48:0] ones;
    ones = (49'd1 << len) - 49'd1;
    return ones[47:0];
  endfunction

`ifdef SSC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wdog_q;
  assign wdog_hit = (wdog_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  assign req_in    = '{dir: req_dir, cmd: req_cmd, len: req_len, div: req_div, data: req_data};
  assign req_ready = (level_q != LW'(FIFO_DEPTH));
  assign push      = req_valid & req_ready;
  assign pop       = (state_q == IDLE) && (level_q != '0) && !sscBusy;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= req_in;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Transaction sequencer; every output it owns is a register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      go_q        <= 1'b0;
      hold_q      <= '0;
      rsp_valid_q <= 1'b0;
      status_q    <= ST_OK;
      rsp_cmd_q   <= '0;
      rsp_data_q  <= '0;
`ifdef SSC_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
`ifdef SSC_TIMEOUT_EN
      if (state_q == LAUNCH || state_q == WAIT_DONE) wdog_q <= wdog_q + 1'b1;
      else                                           wdog_q <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (pop) begin
            hold_q <= head;
            if (head.len > MAX_LEN) begin
              rsp_valid_q <= 1'b1;
              status_q    <= ST_ERR_LEN;
              rsp_cmd_q   <= head.cmd;
              rsp_data_q  <= '0;
              state_q     <= RESPOND;
            end else begin
              go_q    <= 1'b1;
              state_q <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (sscBusy) begin
            go_q    <= 1'b0;
            state_q <= WAIT_DONE;
          end else if (wdog_hit) begin
            go_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            status_q    <= ST_TIMEOUT;
            rsp_cmd_q   <= hold_q.cmd;
            rsp_data_q  <= '0;
            state_q     <= RESPOND;
          end
        end
        WAIT_DONE: begin
          if (!sscBusy) begin
            rsp_valid_q <= 1'b1;
            status_q    <= ST_OK;
            rsp_cmd_q   <= hold_q.cmd;
            rsp_data_q  <= hold_q.dir ? '0 : (sscDataOut & len_mask(hold_q.len));
            state_q     <= RESPOND;
          end else if (wdog_hit) begin
            rsp_valid_q <= 1'b1;
            status_q    <= ST_TIMEOUT;
            rsp_cmd_q   <= hold_q.cmd;
            rsp_data_q  <= '0;
            state_q     <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = status_q;
  assign rsp_cmd       = rsp_cmd_q;
  assign rsp_data      = rsp_data_q;
  assign fifo_level    = level_q;
  assign sscGo         = go_q;
  assign sscDir        = hold_q.dir;
  assign sscCommand    = hold_q.cmd;
  assign sscDataLength = hold_q.len;
  assign sscClkDivider = hold_q.div;
  assign sscDataIn     = hold_q.data;

endmodule

// File: tb/tb_ssc_txn_ctrl.sv
// Self-checking bench for ssc_txn_ctrl: vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model with a behavioural SSC core.
module tb_ssc_txn_ctrl;
  localparam int DEPTH = 4;
  localparam int TO    = 100;

  typedef struct packed {
    logic        dir;
    logic [4:0]  cmd;
    logic [5:0]  len;
    logic [4:0]  div;
    logic [47:0] data;
  } req_t;

  typedef struct {
    req_t        r;
    int          busy;
    logic [47:0] dout;
    logic [1:0]  st;
    logic [47:0] dat;
  } vec_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_dir = 1'b0;
  logic [4:0]  req_cmd = '0;
  logic [5:0]  req_len = '0;
  logic [4:0]  req_div = '0;
  logic [47:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [4:0]  rsp_cmd;
  logic [1:0]  rsp_status;
  logic [47:0] rsp_data;
  logic [2:0]  fifo_level;
  logic        sscGo, sscDir;
  logic [4:0]  sscCommand, sscClkDivider;
  logic [5:0]  sscDataLength;
  logic [47:0] sscDataIn;
  logic        sscBusy = 1'b0;
  logic [47:0] sscDataOut = '0;

  always #5 CLK = ~CLK;

  ssc_txn_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir), .req_cmd(req_cmd),
    .req_len(req_len), .req_div(req_div), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cmd(rsp_cmd),
    .rsp_status(rsp_status), .rsp_data(rsp_data), .fifo_level(fifo_level),
    .sscGo(sscGo), .sscDir(sscDir), .sscCommand(sscCommand), .sscDataLength(sscDataLength),
    .sscClkDivider(sscClkDivider), .sscDataIn(sscDataIn),
    .sscBusy(sscBusy), .sscDataOut(sscDataOut)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model and reference scoreboard state
  bit          cm_en = 1'b1, cm_rand = 1'b0, cm_discard = 1'b0, sb_en = 1'b1;
  bit          rst_prev = 1'b1;
  int          cm_len = 4, cm_cnt = 0, go_rises = 0, rsp_n = 0;
  logic        go_prev = 1'b0;
  logic [47:0] cm_dout_next = '0, cm_cur = '0;
  req_t        fields_prev = '0;
  req_t        exp_q[$], launch_q[$];
  logic [47:0] dout_q[$];

  function automatic req_t cur_fields();
    return {sscDir, sscCommand, sscDataLength, sscClkDivider, sscDataIn};
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  always @(negedge CLK) begin : model
    logic        busy_seen;
    req_t        f, r, l;
    logic [47:0] d, ed;
    logic [1:0]  es;
    logic [63:0] m;
    busy_seen = sscBusy;
    f = cur_fields();
    if (sscGo === 1'b1 && go_prev !== 1'b1) go_rises++;
    go_prev = sscGo;
    if (sscGo === 1'b1) chk("go_while_busy", busy_seen, 0);
    if (busy_seen && !rst_prev) chk("fields_stable_busy", f, fields_prev);
    fields_prev = f;
    rst_prev = reset;
    if (!reset && req_valid && req_ready === 1'b1)
      exp_q.push_back({req_dir, req_cmd, req_len, req_div, req_data});
    if (sb_en && !reset && rsp_valid === 1'b1 && rsp_ready) begin
      rsp_n++;
      if (exp_q.size() == 0) chk("sb_unexpected_rsp", 1, 0);
      else begin
        r = exp_q.pop_front();
        es = 2'b00;
        ed = '0;
        if (r.len > 6'd48) es = 2'b10;
        else if (launch_q.size() == 0 || dout_q.size() == 0) chk("sb_missing_launch", 1, 0);
        else begin
          l = launch_q.pop_front();
          d = dout_q.pop_front();
          chk("sb_launch_fields", l, r);
          m = (64'd1 << r.len) - 64'd1;
          if (!r.dir) ed = d & m[47:0];
        end
        chk("sb_status", rsp_status, es);
        chk("sb_data", rsp_data, ed);
        chk("sb_cmd", rsp_cmd, r.cmd);
      end
    end
    if (cm_en && !sscBusy && sscGo === 1'b1 && cm_cnt == 0) begin
      sscBusy = 1'b1;
      cm_cnt = cm_len;
      launch_q.push_back(f);
      cm_cur = cm_rand ? rnd48() : cm_dout_next;
      sscDataOut = rnd48();
    end else if (sscBusy) begin
      if (cm_cnt > 0) cm_cnt--;
      if (cm_cnt == 0) begin
        sscBusy = 1'b0;
        sscDataOut = cm_cur;
        if (cm_discard) cm_discard = 1'b0;
        else dout_q.push_back(cm_cur);
      end else sscDataOut = rnd48();
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input req_t r);
    {req_dir, req_cmd, req_len, req_div, req_data} = r;
  endtask

  task automatic send(input req_t r);
    bit ok;
    drive(r);
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = req_ready;
      step();
    end
    req_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int limit);
    bit ok;
    ok = rsp_valid;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      ok = rsp_valid;
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  function automatic req_t mkreq(input logic dir, input logic [4:0] cmd, input logic [5:0] len,
                                 input logic [47:0] data);
    req_t r;
    r.dir = dir; r.cmd = cmd; r.len = len; r.div = cmd ^ 5'h15; r.data = data;
    return r;
  endfunction

  function automatic req_t rndreq(input bit allow_bad);
    req_t r;
    r.dir  = 1'($urandom);
    r.cmd  = 5'($urandom);
    r.div  = 5'($urandom);
    r.data = rnd48();
    r.len  = (allow_bad && $urandom_range(0, 9) == 0) ? 6'($urandom_range(49, 63))
                                                      : 6'($urandom_range(0, 48));
    return r;
  endfunction

  function automatic vec_t mk(input logic dir, input logic [4:0] cmd, input logic [5:0] len,
                              input logic [47:0] data, input int busy, input logic [47:0] dout,
                              input logic [1:0] st, input logic [47:0] dat);
    vec_t v;
    v.r = mkreq(dir, cmd, len, data);
    v.busy = busy; v.dout = dout; v.st = st; v.dat = dat;
    return v;
  endfunction

  vec_t tbl[9];
  req_t b2b[8];

  initial begin
    int g0, base, idx, sent;
    bit acc;
    tbl[0] = mk(1'b1, 5'h0A, 6'd16, 48'h1234,         12, 48'hFFFF_FFFF_FFFF, 2'b00, 48'h0);
    tbl[1] = mk(1'b0, 5'h13, 6'd12, 48'h0,             5, 48'h0000_0000_FABC, 2'b00, 48'h0ABC);
    tbl[2] = mk(1'b0, 5'h07, 6'd49, 48'h55,            3, 48'hFFFF_FFFF_FFFF, 2'b10, 48'h0);
    tbl[3] = mk(1'b0, 5'h1F, 6'd0,  48'h0,             2, 48'hFFFF_FFFF_FFFF, 2'b00, 48'h0);
    tbl[4] = mk(1'b0, 5'h01, 6'd48, 48'h0,             4, 48'hA5A5_5A5A_C3C3, 2'b00, 48'hA5A5_5A5A_C3C3);
    tbl[5] = mk(1'b0, 5'h02, 6'd1,  48'h0,             1, 48'h0000_0000_0003, 2'b00, 48'h1);
    tbl[6] = mk(1'b1, 5'h1C, 6'd48, 48'hFFFF_FFFF_FFFF, 6, 48'h1234,          2'b00, 48'h0);
    tbl[7] = mk(1'b0, 5'h04, 6'd63, 48'h0,             3, 48'hFFFF_FFFF_FFFF, 2'b10, 48'h0);
    tbl[8] = mk(1'b0, 5'h05, 6'd47, 48'h0,             7, 48'hFFFF_FFFF_FFFF, 2'b00, 48'h7FFF_FFFF_FFFF);

    repeat (3) step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_cmd", rsp_cmd, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_sscGo", sscGo, 0);
    chk("rst_ssc_fields", cur_fields(), 0);
    reset = 1'b0;
    step();

    // Accept at edge T, sscGo rises on the pop edge T+1
    cm_len = 3;
    drive(mkreq(1'b0, 5'h11, 6'd8, 48'h0));
    req_valid = 1'b1;
    chk("lat_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("lat_T_go", sscGo, 0);
    chk("lat_T_level", fifo_level, 1);
    step();
    chk("lat_T1_go", sscGo, 1);
    chk("lat_T1_level", fifo_level, 0);
    wait_rsp(100);
    consume();

    for (int i = 0; i < 9; i++) begin
      cm_len = tbl[i].busy;
      cm_dout_next = tbl[i].dout;
      g0 = go_rises;
      send(tbl[i].r);
      wait_rsp(200);
      step();
      step();
      chk($sformatf("vec%0d_valid_held", i), rsp_valid, 1);
      chk($sformatf("vec%0d_status", i), rsp_status, tbl[i].st);
      chk($sformatf("vec%0d_data", i), rsp_data, tbl[i].dat);
      chk($sformatf("vec%0d_cmd", i), rsp_cmd, tbl[i].r.cmd);
      chk($sformatf("vec%0d_go_pulses", i), go_rises - g0, (tbl[i].r.len <= 6'd48) ? 1 : 0);
      chk($sformatf("vec%0d_dataIn", i), sscDataIn, tbl[i].r.data);
      chk($sformatf("vec%0d_dataLen", i), sscDataLength, tbl[i].r.len);
      consume();
      chk($sformatf("vec%0d_valid_clr", i), rsp_valid, 0);
    end

    // Back-to-back with the response held: one in RESPOND plus a full FIFO
    cm_rand = 1'b1;
    cm_len = 4;
    for (int i = 0; i < 8; i++) b2b[i] = rndreq(1'b0);
    base = rsp_n;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 8) begin drive(b2b[idx]); req_valid = 1'b1; end
      else req_valid = 1'b0;
      acc = req_valid && req_ready;
      step();
      if (acc) idx++;
    end
    chk("b2b_accepted", idx, 5);
    chk("b2b_req_ready", req_ready, 0);
    chk("b2b_level", fifo_level, 4);
    chk("b2b_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 400 && (idx < 8 || rsp_n - base < 8); c++) begin
      if (idx < 8) begin drive(b2b[idx]); req_valid = 1'b1; end
      else req_valid = 1'b0;
      acc = req_valid && req_ready;
      step();
      if (acc) idx++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_drained", rsp_n - base, 8);
    chk("b2b_level_end", fifo_level, 0);

    // Randomized traffic against the scoreboard
    base = rsp_n;
    sent = 0;
    for (int c = 0; c < 20000 && (sent < 200 || rsp_n - base < 200); c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      cm_len = $urandom_range(1, 6);
      if (!req_valid && sent < 200 && $urandom_range(0, 2) != 0) begin
        drive(rndreq(1'b1));
        req_valid = 1'b1;
      end
      acc = req_valid && req_ready;
      step();
      if (acc) begin sent++; req_valid = 1'b0; end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("rand_all_responded", rsp_n - base, 200);
    step();

    // Reset while the core is busy and two requests are queued
    cm_rand = 1'b0;
    cm_len = 40;
    cm_dout_next = 48'h0000_00C0_FFEE;
    send(mkreq(1'b0, 5'h03, 6'd20, 48'h0));
    send(mkreq(1'b1, 5'h04, 6'd10, 48'h3FF));
    send(mkreq(1'b0, 5'h05, 6'd30, 48'h0));
    step();
    chk("rstx_busy_before", sscBusy, 1);
    chk("rstx_level_before", fifo_level, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    launch_q.delete();
    dout_q.delete();
    cm_discard = 1'b1;
    chk("rstx_level", fifo_level, 0);
    chk("rstx_rsp_valid", rsp_valid, 0);
    chk("rstx_sscGo", sscGo, 0);
    chk("rstx_req_ready", req_ready, 1);
    g0 = go_rises;
    cm_len = 3;
    send(mkreq(1'b0, 5'h06, 6'd24, 48'h0));
    for (int c = 0; c < 100 && sscBusy; c++) step();
    chk("rstx_core_released", sscBusy, 0);
    chk("rstx_no_go_while_busy", go_rises, g0);
    wait_rsp(100);
    chk("rstx_new_status", rsp_status, 0);
    chk("rstx_new_data", rsp_data, 48'h0000_00C0_FFEE & 48'hFF_FFFF);
    consume();

    // Core that never answers
    cm_en = 1'b0;
    sb_en = 1'b0;
    send(mkreq(1'b0, 5'h09, 6'd8, 48'h0));
    step();
    chk("stuck_go_launch", sscGo, 1);
`ifdef SSC_TIMEOUT_EN
    repeat (99) step();
    chk("to_not_early", rsp_valid, 0);
    step();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_status", rsp_status, 2'b11);
    chk("to_data", rsp_data, 0);
    chk("to_cmd", rsp_cmd, 5'h09);
    chk("to_go_dropped", sscGo, 0);
    consume();
`else
    repeat (150) step();
    chk("nto_go_held", sscGo, 1);
    chk("nto_no_rsp", rsp_valid, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("nto_reset_go", sscGo, 0);
`endif
    exp_q.delete();
    launch_q.delete();
    dout_q.delete();
    cm_en = 1'b1;
    sb_en = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
